// File: rtl/cim_norm_sched.sv
// -----------------------------------------------------------------------------
// cim_norm_sched
//
// Round-robin scheduler that shares one CIM floating-point carry/normalization
// datapath between NREQ column accumulators. A granted accumulator result is
// latched into operand registers. It is presented to the datapath with two
// consecutive strobes, and the datapath result is captured one cycle later.
// The result is returned with the requester ID over a valid/ready response port.
//
// Optional feature macro: CIM_NORM_ZERO_BYPASS_EN
//   When defined, a granted operand of zero skips the datapath and goes
//   straight to the response state with exp=0, mant=0 and the latched sign.
//
// Handshakes:
//   req_*  : req_ready[g] is a one-hot, single-cycle grant. It is driven
//            combinationally in IDLE, and the transfer completes in any cycle
//            where req_valid[g] && req_ready[g].
//   rsp_*  : rsp_valid stays high with every rsp_* field held stable until
//            the cycle where rsp_valid && rsp_ready. That cycle completes the
//            transfer.
//
// Ports:
//   clk, RSTN           clock, synchronous active-low reset
//   cfg_infp            FP mode; low blocks new grants; mirrored on dp_infp
//   req_valid/ready     per-requester request handshake
//   req_data            NREQ x 18-bit signed accumulator values
//   req_sign            NREQ x sign
//   req_exp_max         NREQ x 5-bit block max exponent
//   dp_input_number,
//   dp_sign_buf,
//   dp_exp_max          operand registers driven to the datapath
//   dp_accum_out_valid  datapath strobe (ISSUE1, ISSUE2)
//   dp_infp             equals cfg_infp
//   dp_carry_done       datapath done flag, sampled in ISSUE2
//   dp_exp/mant/sign    datapath results, sampled in CAPTURE
//   rsp_valid/ready     response handshake
//   rsp_id/exp/mant/
//   rsp_sign/rsp_err    response payload
//   err_sticky          set on any datapath timeout, cleared only by reset
//   dbg_state           current FSM state (debug)
// -----------------------------------------------------------------------------
module cim_norm_sched #(
  parameter  int NREQ = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 RSTN,
  input  logic                 cfg_infp,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*18-1:0]   req_data,
  input  logic [NREQ-1:0]      req_sign,
  input  logic [NREQ*5-1:0]    req_exp_max,
  output logic [17:0]          dp_input_number,
  output logic                 dp_sign_buf,
  output logic [4:0]           dp_exp_max,
  output logic                 dp_accum_out_valid,
  output logic                 dp_infp,
  input  logic                 dp_carry_done,
  input  logic [4:0]           dp_exp,
  input  logic [2:0]           dp_mant,
  input  logic                 dp_sign,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [4:0]           rsp_exp,
  output logic [2:0]           rsp_mant,
  output logic                 rsp_sign,
  output logic                 rsp_err,
  output logic                 err_sticky,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE1  = 3'd1,
    S_ISSUE2  = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [17:0]       op_data_q;
  logic              op_sign_q;
  logic [4:0]        op_emax_q;
  logic [ID_W-1:0]   op_id_q;
  logic              done_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand_idx;
  logic              grant_en;
  logic [17:0]       sel_data;
  logic              sel_sign;
  logic [4:0]        sel_emax;
  logic              sel_zero;

  // Round-robin pick: scan from rr_ptr upward with wrap, and take the first
  // valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_idx = ID_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_data = '0;
    sel_sign = 1'b0;
    sel_emax = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == grant_idx) begin
        sel_data = req_data[k*18 +: 18];
        sel_sign = req_sign[k];
        sel_emax = req_exp_max[k*5 +: 5];
      end
    end
  end

  assign sel_zero = (sel_data == '0);

  // A grant happens only in IDLE. Gating with RSTN means a requester is never
  // told it was accepted in a cycle whose state update reset will discard.
  assign grant_en = (state_q == S_IDLE) && RSTN && cfg_infp && grant_found;

  always_comb begin
    req_ready = '0;
    if (grant_en) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
`ifdef CIM_NORM_ZERO_BYPASS_EN
          state_d = sel_zero ? S_RESP : S_ISSUE1;
`else
          state_d = S_ISSUE1;
`endif
        end
      end
      S_ISSUE1:  state_d = S_ISSUE2;
      S_ISSUE2:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        // No grant in the handshake cycle; the next one is in IDLE.
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      op_data_q  <= '0;
      op_sign_q  <= 1'b0;
      op_emax_q  <= '0;
      op_id_q    <= '0;
      done_q     <= 1'b0;
      rsp_id     <= '0;
      rsp_exp    <= '0;
      rsp_mant   <= '0;
      rsp_sign   <= 1'b0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        op_data_q <= sel_data;
        op_sign_q <= sel_sign;
        op_emax_q <= sel_emax;
        op_id_q   <= grant_idx;
        rr_ptr_q  <= (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
`ifdef CIM_NORM_ZERO_BYPASS_EN
        if (sel_zero) begin
          rsp_id   <= grant_idx;
          rsp_exp  <= '0;
          rsp_mant <= '0;
          rsp_sign <= sel_sign;
          rsp_err  <= 1'b0;
        end
`endif
      end
      // The datapath needs both strobes. It should report done during the
      // second strobe, so that is the only cycle in which the flag is meaningful.
      if (state_q == S_ISSUE2) begin
        done_q <= dp_carry_done;
      end
      if (state_q == S_CAPTURE) begin
        rsp_id   <= op_id_q;
        rsp_exp  <= dp_exp;
        rsp_mant <= dp_mant;
        rsp_sign <= dp_sign;
        rsp_err  <= !done_q;
        if (!done_q) begin
          err_sticky <= 1'b1;
        end
      end
    end
  end

  assign dp_input_number    = op_data_q;
  assign dp_sign_buf        = op_sign_q;
  assign dp_exp_max         = op_emax_q;
  assign dp_accum_out_valid = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
  assign dp_infp            = cfg_infp;
  assign rsp_valid          = (state_q == S_RESP);
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_cim_norm_sched.sv
// -----------------------------------------------------------------------------
// tb_cim_norm_sched
//
// Bench for cim_norm_sched. A small two-strobe datapath stand-in produces
// exp/mant/sign from the strobed operand:
//   exp  = exp_max + msb(|x|) - 5
//   mant = rounded top bits of |x|
// For example, -88 with exp_max=10 gives exp=11 and mant=3.
//
// A transaction-level model predicts the following from the request inputs:
//   - grants, using a round-robin pointer and a busy flag
//   - response timing, from the grant cycle plus latency
//   - strobe cycles
//   - payload and sticky error
// These predictions are compared against the DUT on every negative edge.
// Directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_cim_norm_sched;

  localparam int NREQ = 4;
  localparam int ID_W = $clog2(NREQ);
  localparam int RW   = ID_W + 10;
`ifdef CIM_NORM_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
  localparam int ZSTB = 0;
`else
  localparam int ZLAT = 4;
  localparam int ZSTB = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RSTN = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                cfg_infp = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*18-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_sign = '0;
  logic [NREQ*5-1:0]   req_exp_max = '0;
  logic [17:0]         dp_input_number;
  logic                dp_sign_buf;
  logic [4:0]          dp_exp_max;
  logic                dp_accum_out_valid;
  logic                dp_infp;
  logic                dp_carry_done;
  logic [4:0]          dp_exp;
  logic [2:0]          dp_mant;
  logic                dp_sign;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [ID_W-1:0]     rsp_id;
  logic [4:0]          rsp_exp;
  logic [2:0]          rsp_mant;
  logic                rsp_sign;
  logic                rsp_err;
  logic                err_sticky;
  logic [2:0]          dbg_state;
  logic                tie_low = 1'b0;

  cim_norm_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .RSTN(RSTN), .cfg_infp(cfg_infp),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_sign(req_sign), .req_exp_max(req_exp_max),
    .dp_input_number(dp_input_number), .dp_sign_buf(dp_sign_buf),
    .dp_exp_max(dp_exp_max), .dp_accum_out_valid(dp_accum_out_valid),
    .dp_infp(dp_infp), .dp_carry_done(dp_carry_done), .dp_exp(dp_exp),
    .dp_mant(dp_mant), .dp_sign(dp_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_exp(rsp_exp), .rsp_mant(rsp_mant), .rsp_sign(rsp_sign),
    .rsp_err(rsp_err), .err_sticky(err_sticky), .dbg_state(dbg_state)
  );

  // ---------------- datapath stand-in ----------------
  function automatic logic [8:0] dp_fn(input logic [17:0] d, input logic [4:0] em, input logic s);
    logic [17:0] a;
    int msb;
    int r;
    a = d[17] ? 18'(-d) : d;
    if (a == '0) return {5'd0, 3'd0, s};
    msb = 0;
    for (int i = 0; i < 18; i++) if (a[i]) msb = i;
    r = (msb >= 2) ? ((int'(a) + (1 << (msb - 2))) >> (msb - 1)) : int'(a);
    return {5'(int'(em) + msb - 5), 3'(r), s};
  endfunction

  logic        stb_q = 1'b0;
  logic [17:0] num_q = '0;
  logic [4:0]  em_q  = '0;
  logic        sg_q  = 1'b0;
  logic [8:0]  out_q = '0;
  always @(posedge clk) begin
    stb_q <= dp_accum_out_valid;
    if (dp_accum_out_valid) begin
      num_q <= dp_input_number;
      em_q  <= dp_exp_max;
      sg_q  <= dp_sign_buf;
      if (stb_q) out_q <= dp_fn(num_q, em_q, sg_q);
    end
  end
  assign {dp_exp, dp_mant, dp_sign} = out_q;
  assign dp_carry_done = stb_q & dp_accum_out_valid & ~tie_low;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [RW-1:0] exp_q[$];
  int            glog_id[$];
  int            glog_cyc[$];
  int            hs_log[$];
  int            stb_cnt = 0;

  bit            m_busy = 0;
  int            m_rr = 0;
  int            m_t = 0;
  int            m_lat = 4;
  bit            m_byp = 0;
  bit            m_err = 0;
  bit            m_sticky = 0;
  logic [23:0]   m_op = '0;
  int            mg;
  bit            mvis, mstb;
  logic [17:0]   md;
  logic [4:0]    mem;
  logic          ms;

  always @(negedge clk) begin
    if (!RSTN) begin
      m_busy = 0; m_rr = 0; m_sticky = 0;
      exp_q.delete();
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k]) begin glog_id.push_back(k); glog_cyc.push_back(cyc); end
      end
      if (dp_accum_out_valid) stb_cnt++;

      // predicted grant
      mg = -1;
      if (!m_busy && cfg_infp) begin
        for (int k = 0; k < NREQ; k++) begin
          if (mg < 0 && req_valid[(m_rr + k) % NREQ]) mg = (m_rr + k) % NREQ;
        end
      end
      check("req_ready", req_ready, (mg >= 0) ? (64'd1 << mg) : 64'd0);

      mvis = m_busy && (cyc >= m_t + m_lat);
      check("rsp_valid", rsp_valid, mvis);
      if (mvis) check("rsp_payload", {rsp_id, rsp_exp, rsp_mant, rsp_sign, rsp_err}, exp_q[0]);
      if (mvis && m_err) m_sticky = 1;
      check("err_sticky", err_sticky, m_sticky);

      mstb = m_busy && !m_byp && (cyc == m_t + 1 || cyc == m_t + 2);
      check("dp_strobe", dp_accum_out_valid, mstb);
      if (mstb) check("dp_operand", {dp_input_number, dp_sign_buf, dp_exp_max}, m_op);
      check("dp_infp", dp_infp, cfg_infp);

      if (mvis && rsp_ready) begin
        m_busy = 0;
        void'(exp_q.pop_front());
        hs_log.push_back(cyc);
      end
      if (mg >= 0) begin
        md  = req_data[mg*18 +: 18];
        mem = req_exp_max[mg*5 +: 5];
        ms  = req_sign[mg];
        m_busy = 1; m_t = cyc; m_rr = (mg + 1) % NREQ;
        m_op = {md, ms, mem};
`ifdef CIM_NORM_ZERO_BYPASS_EN
        m_byp = (md == '0);
`else
        m_byp = 0;
`endif
        m_lat = m_byp ? 1 : 4;
        m_err = m_byp ? 1'b0 : tie_low;
        exp_q.push_back(m_byp ? {ID_W'(mg), 5'd0, 3'd0, ms, 1'b0}
                              : {ID_W'(mg), dp_fn(md, mem, ms), tie_low});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic request(input int i, input int d, input int em, input bit s);
    req_data[i*18 +: 18]  = 18'(d);
    req_exp_max[i*5 +: 5] = 5'(em);
    req_sign[i]           = s;
    req_valid[i]          = 1'b1;
  endtask

  task automatic wait_grant(input int i, output int gc);
    bit got;
    got = 0;
    gc  = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin got = 1; gc = cyc; end
    end
    if (!got) check("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic to_negedge_of(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge clk);
    #1 RSTN = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int gc, gc2, hs, hs0;
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_strobe", dp_accum_out_valid, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_rsp_fields", {rsp_id, rsp_exp, rsp_mant, rsp_sign, rsp_err}, 0);
    check("rst_operand", {dp_input_number, dp_sign_buf, dp_exp_max}, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1 RSTN = 1'b1;

    // single request: -88, exp_max 10, sign 1
    request(0, -88, 10, 1);
    wait_grant(0, gc);
    to_negedge_of(gc + 3);
    check("t1_not_early", rsp_valid, 0);
    to_negedge_of(gc + 4);
    check("t1_valid", rsp_valid, 1);
    check("t1_id", rsp_id, 0);
    check("t1_exp", rsp_exp, 11);
    check("t1_mant", rsp_mant, 3'b011);
    check("t1_sign", rsp_sign, 1);
    check("t1_err", rsp_err, 0);
    @(posedge clk); #1;
    drain();

    // all four continuously valid after reset
    do_reset();
    glog_id.delete(); glog_cyc.delete();
    request(0, 100, 8, 0);
    request(1, -3000, 12, 1);
    request(2, 17, 1, 0);
    request(3, 65000, 20, 0);
    for (int n = 0; n < 100 && glog_id.size() < 5; n++) @(posedge clk);
    #1 req_valid = '0;
    check("rr_count", glog_id.size() >= 5, 1);
    for (int k = 0; k < 5; k++) check("rr_order", (k < glog_id.size()) ? glog_id[k] : -1, exp_ord[k]);
    for (int k = 1; k < 5; k++)
      check("rr_spacing", (k < glog_cyc.size()) ? glog_cyc[k] - glog_cyc[k-1] : -1, 5);
    drain();

    // response back-pressure for 10+ cycles
    rsp_ready = 1'b0;
    request(2, 300, 3, 0);
    request(3, -5, 2, 1);
    wait_grant(2, gc);
    to_negedge_of(gc + 4);
    check("bp_valid", rsp_valid, 1);
    check("bp_id", rsp_id, 2);
    check("bp_exp", rsp_exp, 6);
    check("bp_mant", rsp_mant, 2);
    repeat (10) @(posedge clk);
    #1;
    hs = cyc;
    rsp_ready = 1'b1;
    wait_grant(3, gc2);
    check("bp_grant_after_ready", gc2 - hs, 1);
    drain();

    // datapath timeout
    tie_low = 1'b1;
    request(1, 1000, 4, 0);
    wait_grant(1, gc);
    to_negedge_of(gc + 4);
    check("to_rsp_err", rsp_err, 1);
    check("to_sticky", err_sticky, 1);
    @(posedge clk); #1;
    drain();
    tie_low = 1'b0;
    request(0, 7, 1, 0);
    wait_grant(0, gc);
    to_negedge_of(gc + 4);
    check("to_rsp_err_clear", rsp_err, 0);
    check("to_sticky_held", err_sticky, 1);
    @(posedge clk); #1;
    drain();
    do_reset();
    @(negedge clk);
    check("to_sticky_reset", err_sticky, 0);
    @(posedge clk); #1;

    // cfg_infp dropped during ISSUE1
    request(0, -20, 6, 1);
    wait_grant(0, gc);
    cfg_infp = 1'b0;
    request(1, 55, 2, 0);
    hs0 = hs_log.size();
    glog_id.delete();
    repeat (15) @(posedge clk);
    check("cfg_no_grant", glog_id.size(), 0);
    check("cfg_inflight_done", hs_log.size() - hs0, 1);
    #1 cfg_infp = 1'b1;
    wait_grant(1, gc);
    drain();

    // zero operand
    stb_cnt = 0;
    request(3, 0, 9, 1);
    wait_grant(3, gc);
    to_negedge_of(gc + ZLAT);
    check("z_valid", rsp_valid, 1);
    check("z_id", rsp_id, 3);
    check("z_exp", rsp_exp, 0);
    check("z_mant", rsp_mant, 0);
    check("z_sign", rsp_sign, 1);
    @(posedge clk); #1;
    drain();
    check("z_strobes", stb_cnt, ZSTB);

    // reset mid-operation
    request(2, 123, 5, 0);
    wait_grant(2, gc);
    @(posedge clk); #1;
    RSTN = 1'b0;
    @(posedge clk); #1 RSTN = 1'b1;
    @(negedge clk);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_strobe", dp_accum_out_valid, 0);
    check("mr_state", dbg_state, 0);
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    request(1, 40, 3, 1);
    wait_grant(1, gc);
    to_negedge_of(gc + 4);
    check("mr_recover_id", rsp_id, 1);
    check("mr_recover_valid", rsp_valid, 1);
    @(posedge clk); #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
